// File: rtl/ps2_rx_frame_if.sv
// Interface bundling the PS/2 line inputs, receive enable and the
// byte/strobe outputs of the PS/2 frame receiver.
interface ps2_rx_frame_if;
    logic       ps2d;
    logic       ps2c;
    logic       rx_en;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    // Stimulus / consumer side
    modport master (
        output ps2d, ps2c, rx_en,
        input  dout, rx_done_tick, parity_err, frame_err
    );

    // Receiver side
    modport slave (
        input  ps2d, ps2c, rx_en,
        output dout, rx_done_tick, parity_err, frame_err
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises and de-glitches ps2c/ps2d, samples the
// 11-bit device frame on filtered ps2c falling edges, and delivers each good
// byte with a one-cycle strobe. Bad or aborted frames raise an error strobe
// and are never delivered.
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic            clk,
    input  logic            reset,
    ps2_rx_frame_if.slave   bus
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Two-flop synchronisers; lines idle high so they reset to 1
    logic [1:0]            c_sync_q;
    logic [1:0]            d_sync_q;
    // Filter history and filtered clock
    logic [FILTER_LEN-1:0] filt_q;
    logic                  fclk_q;
    logic                  fclk_d;
    logic                  fall_s;
    // Frame state
    logic [1:0]            state_q, state_d;
    logic [9:0]            b_q, b_d;
    logic [3:0]            n_q, n_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    // Registered outputs
    logic [7:0]            dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;

    // Synchronise the asynchronous PS/2 lines before any use
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
        end else begin
            c_sync_q <= {c_sync_q[0], bus.ps2c};
            d_sync_q <= {d_sync_q[0], bus.ps2d};
        end
    end

    // Filtered clock moves only once the whole history agrees
    always_comb begin
        if (&filt_q) begin
            fclk_d = 1'b1;
        end else if (~|filt_q) begin
            fclk_d = 1'b0;
        end else begin
            fclk_d = fclk_q;
        end
    end

    // A falling edge is the filtered clock leaving 1 for 0
    assign fall_s = fclk_q & ~fclk_d;

    // Filter history shift register and filtered clock register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= {FILTER_LEN{1'b1}};
            fclk_q <= 1'b1;
        end else begin
            filt_q <= {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
            fclk_q <= fclk_d;
        end
    end

    // Frame FSM next-state, shift, counters and output strobes
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall_s && bus.rx_en && !d_sync_q[1]) begin
                    state_d = S_DATA;
                    n_d     = 4'd10;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (fall_s) begin
                    b_d   = {d_sync_q[1], b_q[9:1]};
                    n_d   = n_q - 4'd1;
                    cnt_d = {CW{1'b0}};
                    if (n_q == 4'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // Device stopped clocking: abandon the partial frame
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!b_q[9]) begin
                    ferr_d = 1'b1;
                end else if (!(^b_q[8:0])) begin
                    perr_d = 1'b1;
                end else begin
                    dout_d = b_q[7:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            b_q     <= 10'd0;
            n_q     <= 4'd0;
            cnt_q   <= {CW{1'b0}};
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.parity_err   = perr_q;
    assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: the stimulus side pushes the outcome a
// frame should produce, an independent monitor pops and compares on strobes.
module tb_ps2_rx_frame;

    localparam int FLEN = 8;
    localparam int TOC  = 600;
    localparam int HALF = 20;   // ps2c low time in clk; bit period is 2*HALF

    localparam int K_DONE = 0;
    localparam int K_PERR = 1;
    localparam int K_FERR = 2;
    localparam int K_TOUT = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic reset;
    ps2_rx_frame_if bus ();

    ps2_rx_frame #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TOC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    logic [7:0] exp_dout = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference outcome of a complete frame, from the protocol rules
    function automatic int frame_outcome(input logic [7:0] d, input logic par, input logic stop);
        if (!stop) return K_FERR;
        if (($countones(d) + int'(par)) % 2 == 1) return K_DONE;
        return K_PERR;
    endfunction

    // Monitor: every strobe is popped against the scoreboard
    initial begin
        exp_t e;
        logic [2:0] s;
        int lat;
        forever begin
            @(negedge clk);
            s = {bus.rx_done_tick, bus.parity_err, bus.frame_err};
            if (reset && s != 3'b000) begin
                lat = cyc - last_fall_cyc;
                checks++;
                if ($countones(s) != 1) begin
                    errors++;
                    $display("FAIL onehot: strobes=%b, required exactly one high", s);
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: strobes=%b, required none", s);
                end else begin
                    e = q.pop_front();
                    case (e.kind)
                        K_DONE: begin
                            if (s != 3'b100) begin
                                errors++;
                                $display("FAIL kind: strobes=%b, required rx_done_tick", s);
                            end
                            checks++;
                            if (bus.dout != e.data) begin
                                errors++;
                                $display("FAIL dout: got %h, required %h", bus.dout, e.data);
                            end
                            exp_dout = e.data;
                            checks++;
                            if (lat < 1 || lat > FLEN + 5) begin
                                errors++;
                                $display("FAIL done_latency: got %0d clk, required 1..%0d", lat, FLEN + 5);
                            end
                        end
                        K_PERR: begin
                            if (s != 3'b010) begin
                                errors++;
                                $display("FAIL kind: strobes=%b, required parity_err", s);
                            end
                        end
                        default: begin
                            if (s != 3'b001) begin
                                errors++;
                                $display("FAIL kind: strobes=%b, required frame_err", s);
                            end
                            if (e.kind == K_TOUT) begin
                                checks++;
                                if (lat < TOC || lat > TOC + FLEN + 5) begin
                                    errors++;
                                    $display("FAIL timeout_latency: got %0d clk, required %0d..%0d",
                                             lat, TOC, TOC + FLEN + 5);
                                end
                            end
                        end
                    endcase
                    if (e.kind != K_DONE) begin
                        checks++;
                        if (bus.dout != exp_dout) begin
                            errors++;
                            $display("FAIL dout_hold: got %h, required %h", bus.dout, exp_dout);
                        end
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic v);
        @(negedge clk);
        bus.ps2d = v;
        repeat (HALF / 2) @(negedge clk);
        bus.ps2c = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        bus.ps2c = 1'b1;
        repeat (HALF / 2) @(negedge clk);
    endtask

    // Drive a full frame and register its expected outcome
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic en);
        exp_t e;
        bus.rx_en = en;
        if (en) begin
            e.kind = frame_outcome(d, par, stop);
            e.data = d;
            q.push_back(e);
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        bus.ps2d = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outcomes pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_dout(input string name);
        checks++;
        if (bus.dout !== exp_dout) begin
            errors++;
            $display("FAIL %s: dout=%h, required %h", name, bus.dout, exp_dout);
        end
    endtask

    initial begin
        exp_t e;
        logic [7:0] d;
        logic par, stop, en;
        reset    = 1'b0;
        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        bus.rx_en = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.dout !== 8'h00 || {bus.rx_done_tick, bus.parity_err, bus.frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: dout=%h strobes=%b, required 00/000", bus.dout,
                     {bus.rx_done_tick, bus.parity_err, bus.frame_err});
        end
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Good frame, then same data with wrong parity
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        wait_drain(100);
        send_frame(8'h1C, 1'b1, 1'b1, 1'b1);
        wait_drain(100);
        check_dout("dout_after_parity_err");

        // Short ps2c glitch with ps2d low must not start a frame
        @(negedge clk);
        bus.ps2d = 1'b0;
        bus.ps2c = 1'b0;
        repeat (5) @(negedge clk);
        bus.ps2c = 1'b1;
        repeat (5) @(negedge clk);
        bus.ps2d = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b1);
        wait_drain(100);

        // Partial frame then silence: timeout abort, then recovery
        e.kind = K_TOUT;
        e.data = 8'h00;
        q.push_back(e);
        bus.rx_en = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        bus.ps2d = 1'b1;
        wait_drain(TOC + 100);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        wait_drain(100);

        // Stop bit low, then a frame with receive disabled
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        wait_drain(100);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        wait_drain(100);
        check_dout("dout_after_rx_en_off");
        bus.rx_en = 1'b1;

        // Reset mid-frame, asynchronous to clk
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 8'h00 || {bus.rx_done_tick, bus.parity_err, bus.frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL midframe_reset: dout=%h strobes=%b, required 00/000", bus.dout,
                     {bus.rx_done_tick, bus.parity_err, bus.frame_err});
        end
        exp_dout = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b1, 1'b1);
        wait_drain(100);

        // Randomised frames: mostly good, some parity/stop errors, some disabled
        for (int t = 0; t < 24; t++) begin
            d    = 8'($urandom_range(0, 255));
            par  = ~(^d);
            if ($urandom_range(0, 4) == 0) par = ~par;
            stop = ($urandom_range(0, 7) != 0);
            en   = ($urandom_range(0, 6) != 0);
            send_frame(d, par, stop, en);
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        wait_drain(100);
        check_dout("dout_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
